// File: rtl/mmc_sort_pkg.sv
// Shared types and helpers for the MMC capacitor-voltage sorter.
package mmc_sort_pkg;

  // Default operand width: IEEE-754 binary32.
  localparam int SORT_DW = 32;

  // Sorter control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RANK = 2'd1,
    DONE = 2'd2
  } sort_state_t;

  // Maps a float bit pattern to an unsigned key with the same ordering as
  // the float value. Negative numbers are fully inverted. Non-negative
  // numbers only have the sign bit flipped. NaNs are ordered by bit pattern.
  function automatic logic [SORT_DW-1:0] fp_key(input logic [SORT_DW-1:0] x);
    fp_key = x[SORT_DW-1] ? ~x : (x ^ {1'b1, {(SORT_DW-1){1'b0}}});
  endfunction

endpackage

// File: rtl/mmc_rank_unit.sv
// Combinational rank of one submodule against all latched voltages.
// The rank is the number of other submodules that precede it in insertion
// order. Ties are broken by index, so every submodule has a unique rank.
module mmc_rank_unit
  import mmc_sort_pkg::*;
#(
  parameter int N_SM = 12,
  parameter int DW   = SORT_DW,
  parameter int NW   = $clog2(N_SM + 1)
) (
  input  logic [N_SM*DW-1:0] v_vec,
  input  logic [NW-1:0]      idx,
  input  logic               dir,
  output logic [NW-1:0]      rank
);

  logic [DW-1:0]   key_j;
  logic [N_SM-1:0] prec;

  assign key_j = fp_key(v_vec[idx*DW +: DW]);

  // One comparator per submodule; each decides whether SM gi precedes SM idx.
  generate
    for (genvar gi = 0; gi < N_SM; gi++) begin : g_cmp
      logic [DW-1:0] key_k;
      assign key_k = fp_key(v_vec[gi*DW +: DW]);
      assign prec[gi] = (NW'(gi) == idx)  ? 1'b0 :
                        (key_k == key_j)  ? (NW'(gi) < idx) :
                        dir               ? (key_k > key_j) :
                                            (key_k < key_j);
    end
  endgenerate

  // Popcount of the precedence vector. The result is at most N_SM-1, so it fits in NW bits.
  always_comb begin
    rank = '0;
    for (int i = 0; i < N_SM; i++) begin
      rank = rank + NW'(prec[i]);
    end
  end

endmodule

// File: rtl/mmc_cap_sort_seq.sv
// Sequential MMC arm capacitor-voltage sorter.
// On start it latches the SM voltages, the current direction and the
// insertion count. It then ranks one SM per cycle and publishes the mask.
// Charging current inserts the lowest-voltage SMs; discharging current
// inserts the highest-voltage SMs.
module mmc_cap_sort_seq
  import mmc_sort_pkg::*;
#(
  parameter int N_SM = 12,
  parameter int DW   = SORT_DW,
  parameter int NW   = $clog2(N_SM + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N_SM*DW-1:0] v_flat,
  input  logic [DW-1:0]     i_arm,
  input  logic [NW-1:0]     n_ins,
  output logic              busy,
  output logic              done,
  output logic [N_SM-1:0]   m_out
);

  sort_state_t state_reg, state_next;

  logic [DW-1:0]      v_reg [N_SM];
  logic [N_SM*DW-1:0] v_vec;
  logic               dir_reg;
  logic [NW-1:0]      n_sat_reg;
  logic [NW-1:0]      n_sat_next;
  logic [NW-1:0]      idx_reg;
  logic [N_SM-1:0]    mask_reg;
  logic [N_SM-1:0]    m_out_reg;
  logic               busy_reg;
  logic               done_reg;
  logic [NW-1:0]      rank;

  logic accept;
  logic rank_en;
  logic publish;

  // Only the sign of the arm current matters. The remaining bits are
  // deliberately left unused.
  logic unused_i_arm;
  assign unused_i_arm = &{1'b0, i_arm[DW-2:0]};

  // Clamp the requested insertion count to the number of submodules.
  assign n_sat_next = (n_ins > NW'(N_SM)) ? NW'(N_SM) : n_ins;

  // Next-state and control strobes for the sort sequence.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    rank_en    = 1'b0;
    publish    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RANK;
        end
      end
      RANK: begin
        rank_en = 1'b1;
        if (idx_reg == NW'(N_SM - 1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        publish    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register, sequencing counters and the published outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      m_out_reg <= '0;
      mask_reg  <= '0;
      idx_reg   <= '0;
      dir_reg   <= 1'b0;
      n_sat_reg <= '0;
    end else begin
      state_reg <= state_next;
      done_reg  <= publish;
      if (accept) begin
        dir_reg   <= i_arm[DW-1];
        n_sat_reg <= n_sat_next;
        idx_reg   <= '0;
        mask_reg  <= '0;
        busy_reg  <= 1'b1;
      end
      if (rank_en) begin
        mask_reg[idx_reg] <= (rank < n_sat_reg);
        idx_reg           <= idx_reg + 1'b1;
      end
      if (publish) begin
        m_out_reg <= mask_reg;
        busy_reg  <= 1'b0;
      end
    end
  end

  // Voltage latches. They load only when a sort is accepted and need no reset.
  generate
    for (genvar gi = 0; gi < N_SM; gi++) begin : g_lat
      always_ff @(posedge clk) begin
        if (accept) begin
          v_reg[gi] <= v_flat[gi*DW +: DW];
        end
      end
      assign v_vec[gi*DW +: DW] = v_reg[gi];
    end
  endgenerate

  mmc_rank_unit #(
    .N_SM (N_SM),
    .DW   (DW),
    .NW   (NW)
  ) u_rank (
    .v_vec (v_vec),
    .idx   (idx_reg),
    .dir   (dir_reg),
    .rank  (rank)
  );

  assign busy  = busy_reg;
  assign done  = done_reg;
  assign m_out = m_out_reg;

endmodule
